// File: rtl/countdown_timer_if.sv
// Control and display bundle for the MM:SS countdown timer.
// The master side drives the control pulses and preset; the slave side returns digits and flags.
interface countdown_timer_if;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;
    logic [3:0]  digit_0;
    logic [3:0]  digit_1;
    logic [3:0]  digit_2;
    logic [3:0]  digit_3;
    logic        running;
    logic        done;
    logic        expired;

    modport master (
        output load, load_value, start, pause,
        input  digit_0, digit_1, digit_2, digit_3, running, done, expired
    );

    modport slave (
        input  load, load_value, start, pause,
        output digit_0, digit_1, digit_2, digit_3, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit MM:SS BCD countdown timer with tick prescaler, borrow chain and run-control FSM.
// Digits are registered and feed the seven-segment display path directly.
module countdown_timer #(
    parameter int unsigned FPGA_FREQ = 50_000_000,
    parameter int unsigned TICK_FREQ = 1
) (
    input logic               clk,
    input logic               rst,
    countdown_timer_if.slave  bus
);
    localparam int unsigned DIV = FPGA_FREQ / TICK_FREQ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "countdown_timer: FPGA_FREQ/TICK_FREQ must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
    logic [3:0]    min_ones_q, min_ones_d, min_tens_q, min_tens_d;
    logic          expired_q, expired_d;

    logic       tick, run_step, count_zero;
    logic [3:0] dec_so, dec_st, dec_mo, dec_mt;
    logic       b0, b1, b2;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    assign tick       = (state_q == StRun) && (presc_q == PRESC_MAX);
    assign count_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);

    // Borrow chain: each digit only moves when everything below it wraps.
    always_comb begin
        b0     = (sec_ones_q == 4'd0);
        dec_so = b0 ? 4'd9 : sec_ones_q - 4'd1;
        b1     = b0 && (sec_tens_q == 4'd0);
        dec_st = b0 ? ((sec_tens_q == 4'd0) ? 4'd5 : sec_tens_q - 4'd1) : sec_tens_q;
        b2     = b1 && (min_ones_q == 4'd0);
        dec_mo = b1 ? ((min_ones_q == 4'd0) ? 4'd9 : min_ones_q - 4'd1) : min_ones_q;
        dec_mt = b2 ? min_tens_q - 4'd1 : min_tens_q;
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        expired_d  = 1'b0;
        run_step   = 1'b0;

        if (bus.load) begin
            min_tens_d = clamp(bus.load_value[15:12], 4'd9);
            min_ones_d = clamp(bus.load_value[11:8], 4'd9);
            sec_tens_d = clamp(bus.load_value[7:4], 4'd5);
            sec_ones_d = clamp(bus.load_value[3:0], 4'd9);
            presc_d    = '0;
            state_d    = StIdle;
        end else if (bus.start) begin
            case (state_q)
                StIdle, StPause: begin
                    if (count_zero) begin
                        state_d   = StDone;
                        expired_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StRun:   run_step = 1'b1;
                default: ;
            endcase
        end else if (bus.pause) begin
            // Pause beats a coincident tick: prescaler and digits hold.
            if (state_q == StRun) state_d = StPause;
        end else if (state_q == StRun) begin
            run_step = 1'b1;
        end

        if (run_step) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                sec_ones_d = dec_so;
                sec_tens_d = dec_st;
                min_ones_d = dec_mo;
                min_tens_d = dec_mt;
                if ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000) begin
                    state_d   = StDone;
                    expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            expired_q  <= expired_d;
        end
    end

    assign bus.digit_0 = sec_ones_q;
    assign bus.digit_1 = sec_tens_q;
    assign bus.digit_2 = min_ones_q;
    assign bus.digit_3 = min_tens_q;
    assign bus.running = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.expired = expired_q;
endmodule
